// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared constants for the serial magnitude comparator:
// FSM state encodings, result codes and the result bundle.
package serial_magnitude_comparator_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // {less, great, equal}
    localparam logic [2:0] RES_NONE  = 3'b000;
    localparam logic [2:0] RES_LESS  = 3'b100;
    localparam logic [2:0] RES_GREAT = 3'b010;
    localparam logic [2:0] RES_EQUAL = 3'b001;

    typedef struct packed {
        logic less;
        logic great;
        logic equal;
    } cmp_result_t;

endpackage

// File: rtl/serial_magnitude_comparator_chunk_comparator.sv
// Combinational unsigned compare of one STEP-bit chunk.
// Exactly one of lt/gt/eq is high.
module chunk_comparator #(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0] x,
    input  logic [STEP-1:0] y,
    output logic            lt,
    output logic            gt,
    output logic            eq
);

    assign lt = (x < y);
    assign gt = (x > y);
    assign eq = (x == y);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans STEP-bit chunks MSB first
// and stops at the first differing chunk. Unsigned or two's complement.
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             less,
    output logic             great,
    output logic             equal
);

    localparam int NCHUNK = WIDTH / STEP;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    generate
        if ((WIDTH % STEP) != 0 || WIDTH < 2) begin : g_bad_param
            $error("serial_magnitude_comparator: bad WIDTH/STEP");
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic             mode;
    cmp_result_t      res;

    logic [STEP-1:0]  ca;
    logic [STEP-1:0]  cb;
    logic             c_lt;
    logic             c_gt;
    logic             c_eq;

    // Flipping both sign bits on the top chunk maps signed order onto unsigned.
    always_comb begin
        ca = sh_a[WIDTH-1 -: STEP];
        cb = sh_b[WIDTH-1 -: STEP];
        if (mode && (cnt == LAST)) begin
            ca[STEP-1] = ~ca[STEP-1];
            cb[STEP-1] = ~cb[STEP-1];
        end
    end

    chunk_comparator #(
        .STEP (STEP)
    ) u_chunk (
        .x  (ca),
        .y  (cb),
        .lt (c_lt),
        .gt (c_gt),
        .eq (c_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            cnt   <= '0;
            mode  <= 1'b0;
            res   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        mode  <= signed_mode;
                        cnt   <= LAST;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!c_eq) begin
                        res.less  <= c_lt;
                        res.great <= c_gt;
                        res.equal <= 1'b0;
                        state     <= ST_DONE;
                    end else if (cnt == '0) begin
                        res.less  <= 1'b0;
                        res.great <= 1'b0;
                        res.equal <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        sh_a <= sh_a << STEP;
                        sh_b <= sh_b << STEP;
                        cnt  <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_DONE);
    assign less  = res.less;
    assign great = res.great;
    assign equal = res.equal;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench: 8-bit comparator at STEP=1 and STEP=4,
// checking latency, results, ignored starts and mid-compare reset.
module tb_serial_magnitude_comparator;
    import serial_magnitude_comparator_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       s_start = 1'b0, s_sgn = 1'b0;
    logic [7:0] s_a = '0, s_b = '0;
    logic       s_busy, s_done, s_less, s_great, s_equal;

    logic       q_start = 1'b0, q_sgn = 1'b0;
    logic [7:0] q_a = '0, q_b = '0;
    logic       q_busy, q_done, q_less, q_great, q_equal;

    int vectors = 0;
    int miscompares = 0;
    int ndone;
    int lat;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(8), .STEP(1)) u_s1 (
        .clk (clk), .rst (rst), .start (s_start), .signed_mode (s_sgn),
        .a (s_a), .b (s_b), .busy (s_busy), .done (s_done),
        .less (s_less), .great (s_great), .equal (s_equal)
    );

    serial_magnitude_comparator #(.WIDTH(8), .STEP(4)) u_s4 (
        .clk (clk), .rst (rst), .start (q_start), .signed_mode (q_sgn),
        .a (q_a), .b (q_b), .busy (q_busy), .done (q_done),
        .less (q_less), .great (q_great), .equal (q_equal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int r1();
        return int'({s_less, s_great, s_equal});
    endfunction

    function automatic int r4();
        return int'({q_less, q_great, q_equal});
    endfunction

    initial begin
        tick();
        tick();
        chk("rst_s1_busy", s_busy, 0);
        chk("rst_s1_done", s_done, 0);
        chk("rst_s1_res", r1(), RES_NONE);
        chk("rst_s4_busy", q_busy, 0);
        chk("rst_s4_res", r4(), RES_NONE);
        rst = 1'b0;

        // 80 vs 7F unsigned: first bit differs
        s_a = 8'h80; s_b = 8'h7F; s_sgn = 1'b0; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("gt_busy_t", s_busy, 1);
        chk("gt_done_t", s_done, 0);
        tick();
        chk("gt_done_t1", s_done, 1);
        chk("gt_res_t1", r1(), RES_GREAT);
        chk("gt_busy_t1", s_busy, 1);
        tick();
        chk("gt_busy_t2", s_busy, 0);
        chk("gt_done_t2", s_done, 0);
        chk("gt_hold_t2", r1(), RES_GREAT);

        // A5 == A5: full scan
        s_a = 8'hA5; s_b = 8'hA5; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        chk("eq_done_t7", s_done, 0);
        chk("eq_scan_hold", r1(), RES_GREAT);
        tick();
        chk("eq_done_t8", s_done, 1);
        chk("eq_res_t8", r1(), RES_EQUAL);
        tick();
        chk("eq_busy_t9", s_busy, 0);

        // 01 vs 00: differs only in last bit
        s_a = 8'h01; s_b = 8'h00; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        chk("lsb_done_t7", s_done, 0);
        chk("lsb_hold_t7", r1(), RES_EQUAL);
        tick();
        chk("lsb_done_t8", s_done, 1);
        chk("lsb_res_t8", r1(), RES_GREAT);
        tick();

        // FF vs 01 signed: -1 < 1
        s_a = 8'hFF; s_b = 8'h01; s_sgn = 1'b1; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        tick();
        chk("sgn_done_t1", s_done, 1);
        chk("sgn_res_t1", r1(), RES_LESS);
        tick();

        // same operands unsigned: 255 > 1
        s_sgn = 1'b0; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        tick();
        chk("uns_done_t1", s_done, 1);
        chk("uns_res_t1", r1(), RES_GREAT);
        tick();

        // STEP=4: 35 vs 3A, operands disturbed during scan
        q_a = 8'h35; q_b = 8'h3A; q_sgn = 1'b0; q_start = 1'b1;
        tick();
        q_start = 1'b0;
        q_a = 8'hFF; q_b = 8'h00; q_sgn = 1'b1;
        tick();
        chk("s4_done_t1", q_done, 0);
        tick();
        chk("s4_done_t2", q_done, 1);
        chk("s4_res_t2", r4(), RES_LESS);
        tick();
        chk("s4_busy_t3", q_busy, 0);

        // STEP=4 signed: 80 (-128) vs 70 (112)
        q_a = 8'h80; q_b = 8'h70; q_sgn = 1'b1; q_start = 1'b1;
        tick();
        q_start = 1'b0;
        tick();
        chk("s4_sgn_done", q_done, 1);
        chk("s4_sgn_res", r4(), RES_LESS);
        tick();

        // start pulsed while busy is ignored
        s_a = 8'h10; s_b = 8'h10; s_sgn = 1'b0; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 11; i++) begin
            if (i == 2) begin
                s_start = 1'b1; s_a = 8'h00; s_b = 8'hFF;
            end
            if (i == 3) s_start = 1'b0;
            tick();
            if (s_done) ndone++;
        end
        chk("ign_done_cnt", ndone, 1);
        chk("ign_res", r1(), RES_EQUAL);
        chk("ign_busy", s_busy, 0);

        // reset at t+3 of an equal compare
        s_a = 8'h5A; s_b = 8'h5A; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_busy", s_busy, 0);
        chk("mrst_done", s_done, 0);
        chk("mrst_res", r1(), RES_NONE);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_done) ndone++;
        end
        chk("mrst_no_done", ndone, 0);

        // rst and start on the same edge: reset wins
        s_start = 1'b1; rst = 1'b1;
        tick();
        chk("rst_wins_busy", s_busy, 0);
        rst = 1'b0;

        // 03 vs 07 after reset: first difference in sixth bit
        s_a = 8'h03; s_b = 8'h07; s_sgn = 1'b0;
        tick();
        s_start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (s_done && lat < 0) lat = i;
        end
        chk("post_rst_lat", lat, 6);
        chk("post_rst_res", r1(), RES_LESS);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
